// File: rtl/ocm_arb_pkg.sv
// Shared constants, requester ids and helpers for the OCM round-robin arbiter.
package ocm_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    // Saturating increment for the performance counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ocm_rr_arbiter_if.sv
// Avalon-MM requester port (address/data/handshake) into the OCM arbiter.
interface ocm_rr_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 64
) ();
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ocm_rr_grant.sv
// Two-way round-robin pick with the last-grant history register.
module ocm_rr_grant
    import ocm_arb_pkg::*;
#(
    parameter bit M0_FIRST = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0_c,
    output logic o_gnt1_c
);
    // History starts on the non-favoured side so the favoured requester wins first
    localparam req_id_e RST_LAST = M0_FIRST ? REQ_M1 : REQ_M0;

    req_id_e r_last_gnt;

    always_comb begin
        o_gnt0_c = 1'b0;
        o_gnt1_c = 1'b0;
        if (i_req0 && i_req1) begin
            if (r_last_gnt == REQ_M1) o_gnt0_c = 1'b1;
            else                      o_gnt1_c = 1'b1;
        end else begin
            o_gnt0_c = i_req0;
            o_gnt1_c = i_req1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_last_gnt <= RST_LAST;
        else if (o_gnt0_c) r_last_gnt <= REQ_M0;
        else if (o_gnt1_c) r_last_gnt <= REQ_M1;
    end

endmodule

// File: rtl/ocm_rr_arbiter.sv
// Round-robin arbiter sharing one single-port OCM between two Avalon-MM requesters.
// Optional performance counters enabled with `define OCM_ARB_PERF_CNT_EN.
module ocm_rr_arbiter
    import ocm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned M0_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ocm_rr_arbiter_if.slave       m0,
    ocm_rr_arbiter_if.slave       m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
`ifdef OCM_ARB_PERF_CNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      m0_grant_cnt,
    output logic [CNT_W-1:0]      m1_grant_cnt,
    output logic [CNT_W-1:0]      m0_stall_cnt,
    output logic [CNT_W-1:0]      m1_stall_cnt
`endif
);
    logic    w_req0, w_req1;
    logic    w_gnt0, w_gnt1;
    logic    w_acc_rd;
    logic    w_rdv0, w_rdv1;
    req_id_e w_acc_id;
    logic    r_rd_pend;
    req_id_e r_rd_owner;

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    ocm_rr_grant #(
        .M0_FIRST (M0_FIRST != 0)
    ) u_grant (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req0   (w_req0),
        .i_req1   (w_req1),
        .o_gnt0_c (w_gnt0),
        .o_gnt1_c (w_gnt1)
    );

    assign m0.waitrequest = w_req0 & ~w_gnt0;
    assign m1.waitrequest = w_req1 & ~w_gnt1;

    // RAM pin mux; everything idles low without a grant
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        mem_chipselect = w_gnt0 | w_gnt1;
        if (w_gnt0) begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_writedata  = m0.writedata;
            mem_write      = m0.write;
        end else if (w_gnt1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            mem_write      = m1.write;
        end
    end

    assign mem_clken = 1'b1;

    // A read with write also high is treated as a write only
    assign w_acc_rd = (w_gnt0 & m0.read & ~m0.write) | (w_gnt1 & m1.read & ~m1.write);
    assign w_acc_id = w_gnt1 ? REQ_M1 : REQ_M0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= REQ_M0;
        end else begin
            r_rd_pend <= w_acc_rd;
            if (w_acc_rd) r_rd_owner <= w_acc_id;
        end
    end

    assign w_rdv0 = r_rd_pend & (r_rd_owner == REQ_M0);
    assign w_rdv1 = r_rd_pend & (r_rd_owner == REQ_M1);

    assign m0.readdatavalid = w_rdv0;
    assign m1.readdatavalid = w_rdv1;
    assign m0.readdata      = w_rdv0 ? mem_readdata : '0;
    assign m1.readdata      = w_rdv1 ? mem_readdata : '0;

`ifdef OCM_ARB_PERF_CNT_EN
    logic [CNT_W-1:0] r_m0_grant_cnt, r_m1_grant_cnt;
    logic [CNT_W-1:0] r_m0_stall_cnt, r_m1_stall_cnt;

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m0_grant_cnt <= '0;
            r_m1_grant_cnt <= '0;
            r_m0_stall_cnt <= '0;
            r_m1_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_m0_grant_cnt <= '0;
            r_m1_grant_cnt <= '0;
            r_m0_stall_cnt <= '0;
            r_m1_stall_cnt <= '0;
        end else begin
            if (w_gnt0)         r_m0_grant_cnt <= sat_inc(r_m0_grant_cnt);
            if (w_gnt1)         r_m1_grant_cnt <= sat_inc(r_m1_grant_cnt);
            if (m0.waitrequest) r_m0_stall_cnt <= sat_inc(r_m0_stall_cnt);
            if (m1.waitrequest) r_m1_stall_cnt <= sat_inc(r_m1_stall_cnt);
        end
    end

    assign m0_grant_cnt = r_m0_grant_cnt;
    assign m1_grant_cnt = r_m1_grant_cnt;
    assign m0_stall_cnt = r_m0_stall_cnt;
    assign m1_stall_cnt = r_m1_stall_cnt;
`endif

endmodule

// File: doc/ocm_rr_arbiter.md
Name: ocm_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port 8192x64 on-chip RAM between an HPS-bridge master (m0) and a fabric DMA/logic master (m1).
- Presents two Avalon-MM slave ports with waitrequest and readdatavalid.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken pins. Returns RAM read data to the owning requester.
- Sits between the interconnect and the RAM instance inside the HPS/FPGA subsystem.

Parameters:
- ADDR_W, 13, word address width (8192 x 64-bit words).
- DATA_W, 64, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byteenable width (derived; not overridable).
- M0_FIRST, 1, requester favoured first after reset (1 = m0, 0 = m1).

Ports:
- clk  in  1  single clock for the arbiter and the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_byteenable  in  BE_W  requester 0 byte lanes.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  DATA_W  requester 0 write data.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  DATA_W  read data for requester 0.
- m0_readdatavalid  out  1  m0_readdata valid this cycle.
- m1_*  same set as m0_*, for requester 1.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  BE_W  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_clken  out  1  to RAM clken; constant 1.
- mem_readdata  in  DATA_W  RAM q, valid one clk after the address is presented.

Behaviour:
- Request definition: mX_req = mX_read | mX_write. If read and write are both high, the write is performed and the read is ignored (no readdatavalid).
- Grant is combinational each cycle:
  - Only one requester active: that requester is granted.
  - Both active: the requester that was not granted most recently wins.
  - `last_gnt` register updates on every grant. Its reset value selects the non-favoured requester, so the M0_FIRST requester wins first.
- Acceptance: mX_waitrequest = mX_req & ~gntX. A transfer is accepted in any cycle where mX_req is high and waitrequest is low. Idle requesters see waitrequest = 0.
- Memory mux:
  - mem_address, mem_byteenable and mem_writedata come from the granted requester.
  - mem_chipselect = any grant.
  - mem_write = granted requester's write.
  - With no grant, all mem_* outputs are 0 except mem_clken.
- Read pipeline:
  - On an accepted read, register rd_pend = 1 and rd_owner = granted id.
  - In the following cycle, mX_readdatavalid = rd_pend & (rd_owner == X), and mX_readdata = mem_readdata.
  - Fixed latency is 1 cycle. Throughput is 1 access per cycle with no bubbles. Back-to-back reads from alternating owners are correct.
- readdata when not valid: mX_readdata is gated to 0 whenever mX_readdatavalid is low.
- Write latency: 0. Accepted writes complete at the clk edge; a read of the same address accepted next cycle returns the new data.
- Reset:
  - Asserting reset_n low (async) clears rd_pend, rd_owner and last_gnt.
  - An in-flight read is dropped: no readdatavalid is produced.
  - All outputs are 0 during reset except mem_clken = 1. waitrequest is 0 because the outputs are combinational from requests and grants.
- Fairness: with both requesters continuously active, grants strictly alternate. Starvation cannot exceed 1 cycle.

Optional Feature:
- Macro: OCM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs m0_grant_cnt, m1_grant_cnt and m0_stall_cnt, m1_stall_cnt, each 32 bits.
  - Grant counters count accepted transfers; stall counters count cycles with waitrequest high.
  - All counters saturate at 0xFFFFFFFF and clear on reset.
  - Adds input cnt_clr (1 bit), which synchronously clears all four counters.
  - cnt_clr takes priority over an increment in the same cycle.
- When undefined: the ports and logic are absent and arbitration behaviour is identical.

Decomposition:
- Package ocm_arb_pkg:
  - localparams for ADDR_W and DATA_W defaults and NUM_REQ = 2.
  - Requester-id encoding: REQ_M0 = 1'b0, REQ_M1 = 1'b1.
  - Counter width CNT_W = 32.
- One natural sub-module: ocm_rr_grant. It holds the combinational two-way round-robin pick plus the last_gnt register.
- The top level holds the mux, the read pipeline and the optional counters.

Test Plan:
- Reset, then m0 writes addr 0x0010, data 0x0123456789ABCDEF, byteenable 0xFF. Then m0 reads 0x0010 → m0_readdatavalid one cycle after acceptance with that data; m1_readdatavalid stays 0.
- m0 and m1 both read continuously for 8 cycles (m0 addr 0x0001, m1 addr 0x0002) → grants alternate m0, m1, m0, …; each requester gets 4 readdatavalid pulses with the correct data; each waitrequest is high on alternate cycles.
- Byte-lane write: m1 writes 0xFFFFFFFFFFFFFFFF with byteenable 0x0F to an address holding 0 → a readback returns 0x00000000FFFFFFFF.
- Same-cycle hazard: m0 writes 0xAA..AA to 0x1FFF at cycle N; m1 reads 0x1FFF, accepted at N+1 → m1 receives 0xAA..AA at N+2.
- Reset mid-read: an m1 read is accepted, and reset_n is pulsed low before the next edge → no readdatavalid is produced, and the first post-reset contention is granted to m0 (M0_FIRST = 1).
- With OCM_ARB_PERF_CNT_EN: 10 cycles of full contention → m0_grant_cnt = 5, m1_grant_cnt = 5, each stall_cnt = 5. Pulse cnt_clr → all counters read 0 next cycle.
